router_fsm: RTL and testbench

Packet-sequencing controller for the router's input side. It decodes the 2-bit destination address of each incoming packet and waits for the target output FIFO to drain. It then drives the register block's state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the FIFO write enable through header, payload, FIFO-full stall and parity phases. It sits between the input port, the register block and the synchroniser/FIFO array, and asserts busy to stall the source.

---
 rtl/router_fsm_if.sv | 41 ++++
 rtl/router_fsm.sv | 159 +++++++++++++++
 tb/tb_router_fsm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/router_fsm_if.sv
// Handshake bundle between the router input side, register block and FIFO array
// and the router_fsm packet sequencer.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  rst_int_reg, write_enb_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the router input side (header decode, FIFO
// wait, load, full stall, parity). Define ROUTER_FSM_ADDR_CHECK_EN to drop packets to address 3.
module router_fsm (
  input  logic        clock,
  input  logic        resetn,
  router_fsm_if.slave bus
);

`ifdef ROUTER_FSM_ADDR_CHECK_EN
  localparam int unsigned STATE_W = 4;
`else
  localparam int unsigned STATE_W = 3;
`endif

  typedef enum logic [STATE_W-1:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
`ifdef ROUTER_FSM_ADDR_CHECK_EN
    , DROP_PACKET
`endif
  } state_t;

  // Output vector order: detect, lfd, ld, laf, full, rst_int, write_enb, busy
  localparam logic [7:0] OUT_DA   = 8'b1000_0000;
  localparam logic [7:0] OUT_WTE  = 8'b0000_0001;
  localparam logic [7:0] OUT_LFD  = 8'b0100_0001;
  localparam logic [7:0] OUT_LD   = 8'b0010_0010;
  localparam logic [7:0] OUT_FULL = 8'b0000_1001;
  localparam logic [7:0] OUT_LAF  = 8'b0001_0011;
  localparam logic [7:0] OUT_LP   = 8'b0000_0011;
  localparam logic [7:0] OUT_CPE  = 8'b0000_0101;

  state_t     state_r;
  state_t     next_s;
  logic [1:0] addr_q;
  logic       ignore_r;
  logic [7:0] out_r;
  logic       empty_hdr_s;
  logic       empty_sel_s;
  logic       soft_sel_s;
  logic       addr_ok_s;

  function automatic logic pick(input logic [1:0] sel, input logic f0,
                                input logic f1, input logic f2);
    case (sel)
      2'd0:    pick = f0;
      2'd1:    pick = f1;
      2'd2:    pick = f2;
      default: pick = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] decode(input state_t s);
    case (s)
      DECODE_ADDRESS:     decode = OUT_DA;
      WAIT_TILL_EMPTY:    decode = OUT_WTE;
      LOAD_FIRST_DATA:    decode = OUT_LFD;
      LOAD_DATA:          decode = OUT_LD;
      FIFO_FULL_STATE:    decode = OUT_FULL;
      LOAD_AFTER_FULL:    decode = OUT_LAF;
      LOAD_PARITY:        decode = OUT_LP;
      CHECK_PARITY_ERROR: decode = OUT_CPE;
      default:            decode = OUT_WTE;
    endcase
  endfunction

  assign empty_hdr_s = pick(bus.data_in, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
  assign empty_sel_s = pick(addr_q, bus.fifo_empty_0, bus.fifo_empty_1, bus.fifo_empty_2);
  assign soft_sel_s  = pick(addr_q, bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2);
  assign addr_ok_s   = (bus.data_in != 2'b11);

  // Next-state selection; a soft reset of the selected FIFO abandons the packet
  always_comb begin
    next_s = state_r;
    if ((state_r != DECODE_ADDRESS) && soft_sel_s) begin
      next_s = DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid && addr_ok_s && !ignore_r) begin
            next_s = empty_hdr_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
          end else if (bus.pkt_valid && !addr_ok_s) begin
            next_s = DROP_PACKET;
`endif
          end else begin
            next_s = DECODE_ADDRESS;
          end
        end
        WAIT_TILL_EMPTY: next_s = empty_sel_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA: next_s = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full)       next_s = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) next_s = LOAD_PARITY;
          else                     next_s = LOAD_DATA;
        end
        FIFO_FULL_STATE: next_s = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        next_s = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) next_s = LOAD_PARITY;
          else                        next_s = LOAD_DATA;
        end
        LOAD_PARITY:        next_s = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: next_s = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
        DROP_PACKET:        next_s = bus.pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
`endif
        default:            next_s = DECODE_ADDRESS;
      endcase
    end
  end

  // State, captured address and outputs; outputs are registered from the
  // next-state decode so they always match the state register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r  <= DECODE_ADDRESS;
      addr_q   <= 2'b00;
      ignore_r <= 1'b0;
      out_r    <= OUT_DA;
    end else begin
      state_r <= next_s;
      out_r   <= decode(next_s);
      if ((state_r == DECODE_ADDRESS) && (next_s != DECODE_ADDRESS)) begin
        addr_q <= bus.data_in;
      end else begin
        addr_q <= addr_q;
      end
`ifdef ROUTER_FSM_ADDR_CHECK_EN
      ignore_r <= 1'b0;
`else
      // Bytes following an invalid header must not be mistaken for a header
      if (!bus.pkt_valid) begin
        ignore_r <= 1'b0;
      end else if ((state_r == DECODE_ADDRESS) && !addr_ok_s) begin
        ignore_r <= 1'b1;
      end else begin
        ignore_r <= ignore_r;
      end
`endif
    end
  end

  assign bus.detect_add    = out_r[7];
  assign bus.lfd_state     = out_r[6];
  assign bus.ld_state      = out_r[5];
  assign bus.laf_state     = out_r[4];
  assign bus.full_state    = out_r[3];
  assign bus.rst_int_reg   = out_r[2];
  assign bus.write_enb_reg = out_r[1];
  assign bus.busy          = out_r[0];

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm; expected output vectors per cycle
// are hand-derived from the state sequence of each scenario.
module tb_router_fsm;

  // Observed vector order: detect, lfd, ld, laf, full, rst_int, write_enb, busy
  localparam logic [7:0] DA   = 8'b1000_0000;
  localparam logic [7:0] WTE  = 8'b0000_0001;
  localparam logic [7:0] LFD  = 8'b0100_0001;
  localparam logic [7:0] LD   = 8'b0010_0010;
  localparam logic [7:0] FUL  = 8'b0000_1001;
  localparam logic [7:0] LAF  = 8'b0001_0011;
  localparam logic [7:0] LP   = 8'b0000_0011;
  localparam logic [7:0] CPE  = 8'b0000_0101;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
  localparam logic [7:0] BAD  = 8'b0000_0001;
`else
  localparam logic [7:0] BAD  = 8'b1000_0000;
`endif

  logic clock;
  logic resetn;
  int   vectors;
  int   miscompares;
  logic [7:0] obs;

  router_fsm_if bus ();

  router_fsm dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Stimulus word: resetn, pkt_valid, data_in[1:0], fifo_full, low_pkt_valid,
  // parity_done, soft_reset_0, soft_reset_1, soft_reset_2
  task automatic apply(input logic [9:0] s);
    resetn            = s[9];
    bus.pkt_valid     = s[8];
    bus.data_in       = s[7:6];
    bus.fifo_full     = s[5];
    bus.low_pkt_valid = s[4];
    bus.parity_done   = s[3];
    bus.soft_reset_0  = s[2];
    bus.soft_reset_1  = s[1];
    bus.soft_reset_2  = s[0];
  endtask

  task automatic test_reset();
    apply(10'b0_1_01_0_0_0_000);
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== DA) begin
        $display("FAIL reset cycle %0d: outputs %b, expected %b", i, obs, DA);
        miscompares++;
      end
    end
    apply(10'b1_0_00_0_0_0_000);
    tick();
    vectors++;
    if (obs !== DA) begin
      $display("FAIL reset release: outputs %b, expected %b", obs, DA);
      miscompares++;
    end
  endtask

  task automatic test_payload();
    logic [9:0] st [7];
    logic [7:0] ex [7];
    int wen_cycles;
    st = '{10'b1_1_01_0_0_0_000, 10'b1_1_01_0_0_0_000, 10'b1_1_01_0_0_0_000,
           10'b1_1_01_0_0_0_000, 10'b1_0_01_0_0_0_000, 10'b1_0_01_0_0_0_000,
           10'b1_0_01_0_0_0_000};
    ex = '{LFD, LD, LD, LD, LP, CPE, DA};
    wen_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      tick();
      wen_cycles += int'(bus.write_enb_reg);
      vectors++;
      if (obs !== ex[i]) begin
        $display("FAIL payload step %0d: outputs %b, expected %b", i, obs, ex[i]);
        miscompares++;
      end
    end
    vectors++;
    if (wen_cycles != 4) begin
      $display("FAIL payload write cycles: got %0d, expected 4", wen_cycles);
      miscompares++;
    end
  endtask

  task automatic test_wait_empty();
    logic [9:0] st [10];
    logic [7:0] ex [10];
    st = '{10'b1_1_10_0_0_0_000, 10'b1_1_00_0_0_0_000, 10'b1_1_00_0_0_0_000,
           10'b1_1_00_0_0_0_000, 10'b1_1_00_0_0_0_000, 10'b1_1_00_0_0_0_000,
           10'b1_1_00_0_0_0_000, 10'b1_0_00_0_0_0_000, 10'b1_0_00_0_0_0_000,
           10'b1_0_00_0_0_0_000};
    ex = '{WTE, WTE, WTE, WTE, WTE, LFD, LD, LP, CPE, DA};
    for (int i = 0; i < 10; i++) begin
      bus.fifo_empty_2 = (i >= 5);
      apply(st[i]);
      tick();
      vectors++;
      if (obs !== ex[i]) begin
        $display("FAIL wait_empty step %0d: outputs %b, expected %b", i, obs, ex[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [9:0] st [14];
    logic [7:0] ex [14];
    st = '{10'b1_1_00_0_0_0_000, 10'b1_1_00_0_0_0_000, 10'b1_1_00_1_0_0_000,
           10'b1_1_00_1_0_0_000, 10'b1_1_00_1_0_0_000, 10'b1_1_00_0_0_0_000,
           10'b1_1_00_0_0_0_000, 10'b1_0_00_1_0_0_000, 10'b1_0_00_0_0_0_000,
           10'b1_0_00_0_1_0_000, 10'b1_0_00_1_0_0_000, 10'b1_0_00_1_0_0_000,
           10'b1_0_00_0_0_0_000, 10'b1_0_00_0_1_1_000};
    ex = '{LFD, LD, FUL, FUL, FUL, LAF, LD, FUL, LAF, LP, CPE, FUL, LAF, DA};
    for (int i = 0; i < 14; i++) begin
      apply(st[i]);
      tick();
      vectors++;
      if (obs !== ex[i]) begin
        $display("FAIL fifo_full step %0d: outputs %b, expected %b", i, obs, ex[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_soft_reset();
    logic [9:0] st [13];
    logic [7:0] ex [13];
    bus.fifo_empty_2 = 1'b0;
    st = '{10'b1_1_00_0_0_0_000, 10'b1_1_00_0_0_0_000, 10'b1_1_00_0_0_0_100,
           10'b1_0_00_0_0_0_000, 10'b1_1_01_0_0_0_000, 10'b1_1_01_0_0_0_000,
           10'b1_1_01_0_0_0_100, 10'b1_0_01_0_0_0_000, 10'b1_0_01_0_0_0_000,
           10'b1_0_01_0_0_0_000, 10'b1_1_10_0_0_0_000, 10'b1_1_10_0_0_0_001,
           10'b1_0_10_0_0_0_000};
    ex = '{LFD, LD, DA, DA, LFD, LD, LD, LP, CPE, DA, WTE, DA, DA};
    for (int i = 0; i < 13; i++) begin
      apply(st[i]);
      tick();
      vectors++;
      if (obs !== ex[i]) begin
        $display("FAIL soft_reset step %0d: outputs %b, expected %b", i, obs, ex[i]);
        miscompares++;
      end
    end
    bus.fifo_empty_2 = 1'b1;
  endtask

  task automatic test_bad_addr();
    logic [9:0] st [9];
    logic [7:0] ex [9];
    st = '{10'b1_1_11_0_0_0_000, 10'b1_1_01_0_0_0_000, 10'b1_1_00_0_0_0_000,
           10'b1_0_00_0_0_0_000, 10'b1_1_01_0_0_0_000, 10'b1_1_01_0_0_0_000,
           10'b1_0_01_0_0_0_000, 10'b1_0_01_0_0_0_000, 10'b1_0_01_0_0_0_000};
    ex = '{BAD, BAD, BAD, DA, LFD, LD, LP, CPE, DA};
    for (int i = 0; i < 9; i++) begin
      apply(st[i]);
      tick();
      vectors++;
      if (obs !== ex[i]) begin
        $display("FAIL bad_addr step %0d: outputs %b, expected %b", i, obs, ex[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [9:0] st [5];
    logic [7:0] ex [5];
    st = '{10'b1_1_01_0_0_0_000, 10'b1_1_01_0_0_0_000, 10'b0_1_01_1_0_0_010,
           10'b0_1_01_0_0_0_000, 10'b1_0_00_0_0_0_000};
    ex = '{LFD, LD, DA, DA, DA};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      tick();
      vectors++;
      if (obs !== ex[i]) begin
        $display("FAIL reset_mid step %0d: outputs %b, expected %b", i, obs, ex[i]);
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    bus.fifo_empty_0 = 1'b1;
    bus.fifo_empty_1 = 1'b1;
    bus.fifo_empty_2 = 1'b1;
    apply(10'b0_0_00_0_0_0_000);
    test_reset();
    test_payload();
    test_wait_empty();
    test_fifo_full();
    test_soft_reset();
    test_bad_addr();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
